// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard-unit inputs from ID/EX/MEM stages and pipeline control outputs
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [15:0] stall_count;
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout, stall_count
  );
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/branch/memory-wait hazard control with wait timeout and stall counter
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 15
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  typedef enum logic {RUN, TIMEOUT} state_t;
  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_wait;
  logic       load_use;
  logic       run;
  assign mem_wait = bus.mem_req && !bus.mem_ready;
  assign load_use = bus.ex_mem_read && bus.ex_rd != 5'd0 &&
                    (bus.ex_rd == bus.id_rs1 || (bus.id_uses_rs2 && bus.ex_rd == bus.id_rs2));
  assign run = state == RUN && !mem_wait;
  // Priority: reset, timeout/memory wait freeze, branch flush, load-use bubble, normal flow
  always_comb begin
    bus.pc_write    = !rst && run && (bus.ex_branch_taken || !load_use);
    bus.if_id_write = !rst && run && (bus.ex_branch_taken || !load_use);
    bus.if_id_flush = rst || (run && bus.ex_branch_taken);
    bus.id_ex_flush = rst || (run && (bus.ex_branch_taken || load_use));
    bus.pipe_hold   = !rst && (state == TIMEOUT || mem_wait);
  end
  // Wait-cycle watchdog, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= RUN;
      wait_cnt        <= 8'd0;
      bus.mem_timeout <= 1'b0;
      bus.stall_count <= 16'd0;
    end else begin
      wait_cnt        <= !mem_wait ? 8'd0 : state == RUN ? wait_cnt + 8'd1 : wait_cnt;
      bus.mem_timeout <= bus.mem_timeout || state == TIMEOUT;
      if (state == RUN && mem_wait && wait_cnt == 8'(WAIT_MAX - 1))
        state <= TIMEOUT;
      if (state == RUN && !bus.pc_write && bus.stall_count != 16'hFFFF)
        bus.stall_count <= bus.stall_count + 16'd1;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, giving the maximum consecutive memory-wait cycles before timeout (range 1..255).
REQ-002 SHALL have one clock and reset: asynchronous, active-high, named as the codebase does:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
REQ-003 SHALL have these remaining ports:
- id_rs1  input  5  ID-stage source register 1.
- id_rs2  input  5  ID-stage source register 2.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  5  EX-stage destination register.
- ex_mem_read  input  1  EX instruction is a load.
- ex_branch_taken  input  1  EX resolved taken branch/jump.
- mem_req  input  1  MEM stage holds a load/store.
- mem_ready  input  1  data memory completes this cycle.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register load enable (0 = hold).
- if_id_flush  output  1  IF/ID register loads NOP (00000013) and PC+4 = 0.
- id_ex_flush  output  1  ID/EX register loads bubble.
- pipe_hold  output  1  freezes the ID/EX, EX/MEM and MEM/WB registers.
- mem_timeout  output  1  sticky memory-timeout flag.
- stall_count  output  16  saturating count of stalled cycles.

Function
REQ-004 SHALL define mem_wait = mem_req AND NOT mem_ready.
REQ-005 SHALL define load_use = ex_mem_read AND ex_rd != 0 AND (ex_rd == id_rs1 OR (id_uses_rs2 AND ex_rd == id_rs2)).
REQ-006 SHALL drive pc_write, if_id_write, if_id_flush, id_ex_flush and pipe_hold combinationally in the same cycle from state and inputs, using the priority in REQ-007..REQ-011.
REQ-007 SHALL, in state TIMEOUT, drive pc_write=0, if_id_write=0, pipe_hold=1 and both flushes=0.
REQ-008 SHALL, in state RUN with mem_wait=1, drive pc_write=0, if_id_write=0, pipe_hold=1 and both flushes=0; mem_wait overrides branch and load-use.
REQ-009 SHALL, otherwise, when ex_branch_taken=1, drive pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1 and pipe_hold=0; branch overrides load_use.
REQ-010 SHALL, otherwise, when load_use=1, drive pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0 and pipe_hold=0, giving a one-bubble stall.
REQ-011 SHALL, otherwise, drive pc_write=1, if_id_write=1, both flushes=0 and pipe_hold=0.
REQ-012 SHALL implement an FSM with states RUN and TIMEOUT:
- RUN stays RUN unless the timeout condition in REQ-013 occurs.
- TIMEOUT is left only by rst.
REQ-013 SHALL keep an 8-bit wait_cnt:
- Increments each RUN cycle with mem_wait=1.
- Clears to 0 on any cycle with mem_wait=0.
- When mem_wait=1 and wait_cnt == WAIT_MAX-1, moves to TIMEOUT on that clock edge.
- So WAIT_MAX consecutive wait cycles cause TIMEOUT.
REQ-014 SHALL set mem_timeout=1 in the cycle after entering TIMEOUT and hold it until rst.
REQ-015 SHALL increment stall_count on each clock edge where pc_write=0, the state is RUN and rst=0, saturating at 16'hFFFF.
REQ-016 SHALL treat ex_rd=0 as never hazardous, with no load-use stall.
REQ-017 SHALL, when mem_ready=1 arrives, make the stall end in that same cycle, so outputs follow REQ-009..REQ-011.

Reset
REQ-018 SHALL, while rst=1, force state=RUN, wait_cnt=0, stall_count=0 and mem_timeout=0 asynchronously.
REQ-019 SHALL, while rst=1, drive pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1 and pipe_hold=0.
REQ-020 SHALL, on rst asserted mid-wait or in TIMEOUT, abandon all state and resume in RUN on the first edge after deassertion.

Verification
REQ-021 SHALL cover these directed scenarios:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1; stall_count 0->1.
- x0 load: ex_mem_read=1, ex_rd=0, id_rs1=0 -> pc_write=1, no flush, stall_count unchanged.
- Branch plus load-use same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1, stall_count unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> pipe_hold=1 for 3 cycles, then 0; stall_count=3; mem_timeout=0.
- Timeout: WAIT_MAX=4, mem_wait held -> TIMEOUT after 4th edge, mem_timeout=1 next cycle; it stays 1 after mem_ready=1; pulsing rst clears everything to reset values.
- Saturation: force 65535 stalled cycles -> stall_count=FFFF and holds.
